// File: rtl/alu_operand_stage.sv
// Operand stage: selects and bypass-forwards ALU operands from decode, then
// holds them in a one-entry valid/ready output register for execute.
module alu_operand_stage #(
  parameter int XLEN         = 32,
  parameter int NFWD         = 2,
  parameter int SRCA_SEL_LEN = 2,
  parameter int SRCB_SEL_LEN = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SRCA_SEL_LEN-1:0] srca_sel,
  input  logic [SRCB_SEL_LEN-1:0] srcb_sel,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1,
  input  logic [XLEN-1:0]         rs2,
  input  logic [XLEN-1:0]         pc,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [XLEN-1:0]         imm_s,
  input  logic [XLEN-1:0]         imm_u,
  input  logic [XLEN-1:0]         imm_j,
  input  logic [NFWD-1:0]         fwd_valid,
  input  logic [5*NFWD-1:0]       fwd_rd,
  input  logic [XLEN*NFWD-1:0]    fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         srca,
  output logic [XLEN-1:0]         srcb,
  output logic [XLEN-1:0]         store_data,
  output logic [XLEN-1:0]         out_pc
);

  localparam logic [SRCA_SEL_LEN-1:0] SRCA_RS1   = SRCA_SEL_LEN'(0);
  localparam logic [SRCA_SEL_LEN-1:0] SRCA_PC    = SRCA_SEL_LEN'(1);
  localparam logic [SRCB_SEL_LEN-1:0] SRCB_RS2   = SRCB_SEL_LEN'(0);
  localparam logic [SRCB_SEL_LEN-1:0] SRCB_IMM_I = SRCB_SEL_LEN'(1);
  localparam logic [SRCB_SEL_LEN-1:0] SRCB_IMM_S = SRCB_SEL_LEN'(2);
  localparam logic [SRCB_SEL_LEN-1:0] SRCB_IMM_U = SRCB_SEL_LEN'(3);
  localparam logic [SRCB_SEL_LEN-1:0] SRCB_IMM_J = SRCB_SEL_LEN'(4);
  localparam logic [SRCB_SEL_LEN-1:0] SRCB_FOUR  = SRCB_SEL_LEN'(5);

  logic            accept;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] srca_next;
  logic [XLEN-1:0] srcb_next;

  // Handshake: a transfer happens on an edge where valid && ready are both 1.
  // in_ready depends only on the output register (never on in_valid), and
  // out_valid/data stay stable until out_ready; flush beats everything but reset.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Scan from oldest to youngest so the lowest matching index wins.
  always_comb begin
    rs1_fwd = rs1;
    rs2_fwd = rs2;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (rs1_addr != 5'd0) && (fwd_rd[5*i +: 5] == rs1_addr))
        rs1_fwd = fwd_data[XLEN*i +: XLEN];
      if (fwd_valid[i] && (rs2_addr != 5'd0) && (fwd_rd[5*i +: 5] == rs2_addr))
        rs2_fwd = fwd_data[XLEN*i +: XLEN];
    end
  end

  always_comb begin
    srca_next = '0;
    case (srca_sel)
      SRCA_RS1: srca_next = rs1_fwd;
      SRCA_PC:  srca_next = pc;
      default:  srca_next = '0;
    endcase
  end

  always_comb begin
    srcb_next = '0;
    case (srcb_sel)
      SRCB_RS2:   srcb_next = rs2_fwd;
      SRCB_IMM_I: srcb_next = imm_i;
      SRCB_IMM_S: srcb_next = imm_s;
      SRCB_IMM_U: srcb_next = imm_u;
      SRCB_IMM_J: srcb_next = imm_j;
      SRCB_FOUR:  srcb_next = XLEN'(4);
      default:    srcb_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      srca       <= '0;
      srcb       <= '0;
      store_data <= '0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      srca       <= srca_next;
      srcb       <= srcb_next;
      store_data <= rs2_fwd;
      out_pc     <= pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic,
// checked by a reference model feeding an expected queue and a drain monitor.
module tb_alu_operand_stage;
  localparam int XLEN = 32;
  localparam int NFWD = 2;
  localparam int W    = 4 * XLEN;

  localparam logic [1:0] SRCA_RS1   = 2'd0;
  localparam logic [1:0] SRCA_PC    = 2'd1;
  localparam logic [2:0] SRCB_RS2   = 3'd0;
  localparam logic [2:0] SRCB_IMM_I = 3'd1;
  localparam logic [2:0] SRCB_IMM_S = 3'd2;
  localparam logic [2:0] SRCB_IMM_U = 3'd3;
  localparam logic [2:0] SRCB_IMM_J = 3'd4;
  localparam logic [2:0] SRCB_FOUR  = 3'd5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           srca_sel;
  logic [2:0]           srcb_sel;
  logic [4:0]           rs1_addr, rs2_addr;
  logic [XLEN-1:0]      rs1, rs2, pc, imm_i, imm_s, imm_u, imm_j;
  logic [NFWD-1:0]      fwd_valid;
  logic [5*NFWD-1:0]    fwd_rd;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      srca, srcb, store_data, out_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic model_valid = 1'b0;

  alu_operand_stage #(.XLEN(XLEN), .NFWD(NFWD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .srca_sel(srca_sel), .srcb_sel(srcb_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .pc(pc), .imm_i(imm_i), .imm_s(imm_s), .imm_u(imm_u),
    .imm_j(imm_j), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .srca(srca),
    .srcb(srcb), .store_data(store_data), .out_pc(out_pc)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rules written directly from the operand definitions.
  function automatic logic [XLEN-1:0] ref_fwd(input logic [4:0] addr, input logic [XLEN-1:0] regv);
    if (addr == 5'd0) return regv;
    for (int i = 0; i < NFWD; i++)
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == addr) return fwd_data[XLEN*i +: XLEN];
    return regv;
  endfunction

  function automatic logic [W-1:0] ref_entry();
    logic [XLEN-1:0] a, b;
    case (srca_sel)
      SRCA_RS1: a = ref_fwd(rs1_addr, rs1);
      SRCA_PC:  a = pc;
      default:  a = '0;
    endcase
    case (srcb_sel)
      SRCB_RS2:   b = ref_fwd(rs2_addr, rs2);
      SRCB_IMM_I: b = imm_i;
      SRCB_IMM_S: b = imm_s;
      SRCB_IMM_U: b = imm_u;
      SRCB_IMM_J: b = imm_j;
      SRCB_FOUR:  b = 32'd4;
      default:    b = '0;
    endcase
    return {a, b, ref_fwd(rs2_addr, rs2), pc};
  endfunction

  // Model: tracks occupancy, checks handshake outputs, pushes expected entries.
  always @(negedge clk) begin
    logic acc;
    if (!rst_n) begin
      exp_q.delete();
      model_valid = 1'b0;
    end else begin
      check("out_valid", XLEN'(out_valid), XLEN'(model_valid));
      check("in_ready", XLEN'(in_ready), XLEN'(!model_valid || out_ready));
      acc = in_valid && (!model_valid || out_ready) && !flush;
      if (flush && model_valid && !out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_entry());
      if (flush)          model_valid = 1'b0;
      else if (acc)       model_valid = 1'b1;
      else if (out_ready) model_valid = 1'b0;
    end
  end

  // Monitor: every transfer to execute is compared against the queue head.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: output srca=%h with empty expected queue at %0t", srca, $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_srca", srca, e[4*XLEN-1:3*XLEN]);
        check("sb_srcb", srcb, e[3*XLEN-1:2*XLEN]);
        check("sb_store_data", store_data, e[2*XLEN-1:XLEN]);
        check("sb_out_pc", out_pc, e[XLEN-1:0]);
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0;
    srca_sel = SRCA_RS1; srcb_sel = SRCB_RS2; rs1_addr = 0; rs2_addr = 0;
    rs1 = 0; rs2 = 0; pc = 0; imm_i = 0; imm_s = 0; imm_u = 0; imm_j = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic random_inputs();
    in_valid  = ($urandom_range(0, 3) != 0);
    srca_sel  = 2'($urandom_range(0, 3));
    srcb_sel  = 3'($urandom_range(0, 7));
    rs1_addr  = 5'($urandom_range(0, 7));
    rs2_addr  = 5'($urandom_range(0, 7));
    rs1 = $urandom; rs2 = $urandom; pc = $urandom;
    imm_i = $urandom; imm_s = $urandom; imm_u = $urandom; imm_j = $urandom;
    fwd_valid = NFWD'($urandom_range(0, (1 << NFWD) - 1));
    for (int i = 0; i < NFWD; i++) begin
      fwd_rd[5*i +: 5]         = 5'($urandom_range(0, 7));
      fwd_data[XLEN*i +: XLEN] = $urandom;
    end
    out_ready = ($urandom_range(0, 2) != 0);
    flush     = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (3) step();
    check("rst_out_valid", XLEN'(out_valid), '0);
    check("rst_srca", srca, '0);
    check("rst_srcb", srcb, '0);
    rst_n = 1;

    // rs1 plus negative I-immediate
    in_valid = 1; rs1_addr = 5'd3; rs1 = 32'd5; srca_sel = SRCA_RS1;
    srcb_sel = SRCB_IMM_I; imm_i = 32'hFFFF_FFFD;
    step();
    in_valid = 0;
    check("d1_out_valid", XLEN'(out_valid), 32'd1);
    check("d1_srca", srca, 32'd5);
    check("d1_srcb", srcb, 32'hFFFF_FFFD);
    out_ready = 1;
    step();
    out_ready = 0;

    // both bypass sources match: youngest wins; then index 0 never forwards
    in_valid = 1; rs1_addr = 5'd7; rs1 = 32'h99; srcb_sel = SRCB_FOUR;
    fwd_valid = 2'b11; fwd_rd = {5'd7, 5'd7}; fwd_data = {32'h22, 32'h11};
    step();
    check("d2_srca_youngest", srca, 32'h11);
    rs1_addr = 5'd0; rs1 = 32'h55; out_ready = 1;
    step();
    check("d2_srca_x0", srca, 32'h55);
    check("d2_valid_b2b", XLEN'(out_valid), 32'd1);

    // stall with churning inputs: held operands must not move
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      rs1 = $urandom; fwd_data = {$urandom, $urandom}; rs1_addr = 5'd7;
      step();
      check("d3_stall_in_ready", XLEN'(in_ready), 32'd0);
      check("d3_stall_srca", srca, 32'h55);
    end
    out_ready = 1; fwd_valid = 0;
    srca_sel = SRCA_PC; srcb_sel = SRCB_FOUR; pc = 32'h100;
    step();
    check("d3_valid_kept", XLEN'(out_valid), 32'd1);
    check("d4_srca_pc", srca, 32'h100);
    check("d4_srcb_four", srcb, 32'd4);
    check("d4_out_pc", out_pc, 32'h100);

    // rs2 forwarded into both srcb and store_data
    srcb_sel = SRCB_RS2; rs2_addr = 5'd9; rs2 = 32'h1;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd9}; fwd_data = {32'h0, 32'hAB};
    step();
    check("d4_srcb_rs2", srcb, 32'hAB);
    check("d4_store_data", store_data, 32'hAB);

    // flush while holding and offered a new request
    out_ready = 0;
    step();
    flush = 1; in_valid = 1; pc = 32'h200;
    step();
    flush = 0;
    check("d5_flush_valid", XLEN'(out_valid), 32'd0);
    check("d5_flush_noload", out_pc, 32'h100);

    // reset during a stall drops everything
    step();
    in_valid = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    check("d5_rst_valid", XLEN'(out_valid), 32'd0);
    check("d5_rst_srca", srca, 32'd0);
    check("d5_rst_srcb", srcb, 32'd0);
    check("d5_rst_store", store_data, 32'd0);
    check("d5_rst_pc", out_pc, 32'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        out_ready = 0;
      end else begin
        rst_n = 1;
      end
      step();
    end

    idle_inputs();
    rst_n = 1;
    out_ready = 1;
    repeat (3) step();
    check("final_queue_empty", XLEN'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
